codec_sample_feeder: RTL
========================

# codec_sample_feeder

Playback-side stage directly upstream of the AC97 codec interface. Buffers stereo 16-bit PCM samples from a producer such as a tone or note generator in a small FIFO, using a valid/ready handshake. Presents one sample per codec frame on PCM_Playback_Left/Right. The presented value changes only in the cycle the codec latches it, so the codec never sees inputs change at the wrong time.

## Interface
- FIFO_DEPTH, 8, number of stereo entries; power of two, ≥2
- SAMPLE_W, 16, bits per channel
- clk  in  1  system clock, same clock as the codec's ClkIn
- reset_n  in  1  asynchronous, active-low reset
- in_left  in  SAMPLE_W  producer left sample, two's complement
- in_right  in  SAMPLE_W  producer right sample
- in_valid  in  1  producer offers {in_left,in_right}
- in_ready  out  1  FIFO not full; write occurs when in_valid & in_ready
- PCM_Playback_Accept  in  1  codec frame strobe, registered level in the codec
- PCM_Playback_Left  out  SAMPLE_W  to codec
- PCM_Playback_Right  out  SAMPLE_W  to codec
- fill_level  out  $clog2(FIFO_DEPTH)+1  entries currently held
- underrun_count  out  8  saturating count of frames served while empty
- volume_shift  in  4  present only with CODEC_FEEDER_VOLUME_EN

## Operation
- Edge detect: accept_q <= PCM_Playback_Accept; take = PCM_Playback_Accept & ~accept_q. This matches the codec's own one-cycle new-frame pulse.
- Output path:
  - PCM_Playback_* = take ? (empty ? hold : head) : hold.
  - hold is a register that loads that same value at the take edge.
  - The path from accept to output is combinational by design, so the codec latches exactly the value held afterwards.
- Pop: at the take edge, if not empty, read pointer advances. If empty, hold is unchanged (last sample repeats) and underrun_count increments, saturating at 255.
- Push: on in_valid & in_ready, the entry is written at the write pointer and the write pointer advances.
- Simultaneous push and pop: both happen and fill_level is unchanged.
  - When full, in_ready=0, so there is no push. Pop still frees a slot, and in_ready rises next cycle.
  - When empty, a sample pushed in the take cycle is not served in that frame.
- Pointers are $clog2(FIFO_DEPTH)+1 bits wide with a wrap bit.
  - full = MSBs differ and lower bits are equal; empty = pointers equal.
- Reset values: pointers 0, hold 0, accept_q 0, underrun_count 0, fill_level 0, in_ready 1, PCM_Playback_* 0.
- Reset mid-operation discards FIFO contents. Outputs return to 0 asynchronously.

## Timing
- Write-to-availability: an entry written at edge N is eligible for a take in cycle N+1 onward.
- The presented value is stable at all posedges except the take edge, where it updates (hold loads).
- in_ready and fill_level are registered-derived and reflect state after the last edge.
- Throughput: one pop per codec frame, one push per cycle.

## Configuration
- CODEC_FEEDER_VOLUME_EN defined:
  - volume_shift port exists.
  - head is arithmetic-right-shifted by volume_shift per channel before the output mux and hold load (sign preserved; e.g. shift 15 turns 16'h8000 into 16'hFFFF).
  - volume_shift is sampled combinationally in the take cycle only.
- Not defined: no port, no shifter; head passes through unchanged.

## Structure
- Package codec_pkg: SAMPLE_W constant, stereo_sample_t packed struct {left,right}, UNDERRUN_MAX=8'hFF.
- One sub-module, codec_feeder_fifo: storage, pointers, full/empty, fill_level.
- Edge detect, output mux, hold, and volume logic stay in the top.

## Test plan
- Reset, then accept pulses with no writes → outputs stay 0, underrun_count reaches 3 after 3 pulses, and the codec model reports no error.
- Push 0x1111/0x2222 then 0x3333/0x4444, then 2 pulses → outputs 0x1111/0x2222 after the first, 0x3333/0x4444 after the second. Outputs are stable between pulses and fill_level goes 2→1→0.
- Fill 8 entries → in_ready=0 and a 9th offer is held. Next pulse → in_ready=1 the following cycle, the 9th is accepted, fill_level=8.
- Push asserted in the same cycle as a take with FIFO_DEPTH entries minus 1 → fill_level unchanged and no entry lost or duplicated over 8 subsequent pulses.
- Drain to empty, then 2 pulses → last sample repeats and underrun_count increments by 2. Force 300 underruns → saturates at 255.
- With CODEC_FEEDER_VOLUME_EN: volume_shift=1, push 0x8000/0x0100 → outputs 0xC000/0x0080. Also assert reset_n low mid-stream → outputs 0 immediately and fill_level 0.

Source files
------------

// File: rtl/codec_pkg.sv
// Shared constants and types for the codec playback feeder.
package codec_pkg;

    localparam int SAMPLE_W = 16;

    typedef struct packed {
        logic [SAMPLE_W-1:0] left;
        logic [SAMPLE_W-1:0] right;
    } stereo_sample_t;

    localparam logic [7:0] UNDERRUN_MAX = 8'hFF;

    // Saturating increment used by the underrun counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        if (value == UNDERRUN_MAX) begin
            return value;
        end else begin
            return value + 8'd1;
        end
    endfunction

endpackage

// File: rtl/codec_feeder_fifo.sv
// Stereo sample FIFO: storage, wrap-bit pointers, full/empty flags and fill level.
module codec_feeder_fifo
    import codec_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 2 * SAMPLE_W
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      wr_en_i,
    input  logic [DATA_W-1:0]         wr_data_i,
    input  logic                      rd_en_i,
    output logic [DATA_W-1:0]         rd_data_o,
    output logic                      full_o,
    output logic                      empty_o,
    output logic [$clog2(DEPTH):0]    fill_level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q;
    logic [AW:0]       wr_ptr_d;
    logic [AW:0]       rd_ptr_q;
    logic [AW:0]       rd_ptr_d;

    // Pointer advance; callers only write when not full and read when not empty.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (rd_en_i) begin
            rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Sample storage; contents are meaningless until written, so no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
        end
    end

    assign rd_data_o    = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o      = (wr_ptr_q == rd_ptr_q);
    assign full_o       = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                          (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fill_level_o = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/codec_sample_feeder.sv
// Buffers producer samples and presents one per codec frame to the AC97 interface.
// Optional macro CODEC_FEEDER_VOLUME_EN adds a per-channel arithmetic volume shift.
module codec_sample_feeder #(
    parameter int FIFO_DEPTH = 8,
    parameter int SAMPLE_W   = codec_pkg::SAMPLE_W
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [SAMPLE_W-1:0]           in_left,
    input  logic [SAMPLE_W-1:0]           in_right,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          PCM_Playback_Accept,
`ifdef CODEC_FEEDER_VOLUME_EN
    input  logic [3:0]                    volume_shift,
`endif
    output logic [SAMPLE_W-1:0]           PCM_Playback_Left,
    output logic [SAMPLE_W-1:0]           PCM_Playback_Right,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic [7:0]                    underrun_count
);

    import codec_pkg::*;

    logic                    accept_q;
    logic                    take_s;
    logic                    pop_s;
    logic                    push_s;
    logic                    full_s;
    logic                    empty_s;
    logic [2*SAMPLE_W-1:0]   head_s;
    logic [SAMPLE_W-1:0]     scaled_left_s;
    logic [SAMPLE_W-1:0]     scaled_right_s;
    logic [SAMPLE_W-1:0]     hold_left_q;
    logic [SAMPLE_W-1:0]     hold_right_q;
    logic [SAMPLE_W-1:0]     out_left_d;
    logic [SAMPLE_W-1:0]     out_right_d;
    logic [7:0]              underrun_q;
    logic [7:0]              underrun_d;

    codec_feeder_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (2 * SAMPLE_W)
    ) u_fifo (
        .clk_i        (clk),
        .rst_ni       (reset_n),
        .wr_en_i      (push_s),
        .wr_data_i    ({in_left, in_right}),
        .rd_en_i      (pop_s),
        .rd_data_o    (head_s),
        .full_o       (full_s),
        .empty_o      (empty_s),
        .fill_level_o (fill_level)
    );

`ifdef CODEC_FEEDER_VOLUME_EN
    assign scaled_left_s  = $signed(head_s[2*SAMPLE_W-1:SAMPLE_W]) >>> volume_shift;
    assign scaled_right_s = $signed(head_s[SAMPLE_W-1:0]) >>> volume_shift;
`else
    assign scaled_left_s  = head_s[2*SAMPLE_W-1:SAMPLE_W];
    assign scaled_right_s = head_s[SAMPLE_W-1:0];
`endif

    // Frame edge, pop/push decisions, output mux and underrun accounting.
    always_comb begin
        take_s      = PCM_Playback_Accept & ~accept_q;
        pop_s       = take_s & ~empty_s;
        push_s      = in_valid & ~full_s;
        out_left_d  = hold_left_q;
        out_right_d = hold_right_q;
        underrun_d  = underrun_q;
        if (pop_s) begin
            out_left_d  = scaled_left_s;
            out_right_d = scaled_right_s;
        end else begin
            out_left_d  = hold_left_q;
            out_right_d = hold_right_q;
        end
        if (take_s && empty_s) begin
            underrun_d = sat_inc8(underrun_q);
        end else begin
            underrun_d = underrun_q;
        end
    end

    // Edge-detect flop, held output sample and underrun counter.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            accept_q     <= 1'b0;
            hold_left_q  <= '0;
            hold_right_q <= '0;
            underrun_q   <= 8'd0;
        end else begin
            accept_q     <= PCM_Playback_Accept;
            hold_left_q  <= out_left_d;
            hold_right_q <= out_right_d;
            underrun_q   <= underrun_d;
        end
    end

    // The codec latches on the take edge, so the mux is intentionally combinational.
    assign PCM_Playback_Left  = out_left_d;
    assign PCM_Playback_Right = out_right_d;
    assign in_ready           = ~full_s;
    assign underrun_count     = underrun_q;

endmodule
